// File: rtl/pwm_pkg.sv
// Shared constants and types for the PWM generator/capture pair.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package pwm_pkg;

    // Measurement/counter width shared with the generator's Load register.
    localparam int PWM_WIDTH       = 12;
    // Default synchroniser depth on an asynchronous PWM input.
    localparam int PWM_SYNC_STAGES = 2;
    // Default number of cycles without a rising edge before a stuck input is flagged.
    localparam int PWM_TIMEOUT     = 4095;

    // Capture FSM states.
    typedef enum logic [1:0] {
        S_WAIT = 2'd0,
        S_HIGH = 2'd1,
        S_LOW  = 2'd2
    } pwm_state_t;

endpackage

// File: rtl/pwm_sync_edge.sv
// Synchronises an asynchronous PWM input and produces registered rise/fall pulses.
// Latency: level after SYNC_STAGES clocks, rise/fall pulses one clock after the edge flop sees it.
// Backpressure: none; free-running, one pulse per detected edge.
//
// Ports:
//   Clock    in   1  clock, posedge
//   Reset_n  in   1  synchronous active-low reset
//   PWM_i    in   1  asynchronous PWM input
//   level    out  1  synchronised level
//   rise     out  1  1-cycle pulse per synchronised rising edge
//   fall     out  1  1-cycle pulse per synchronised falling edge
module pwm_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic Clock,
    input  logic Reset_n,
    input  logic PWM_i,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_d;
    // Fills with ones after reset; edges are only reported once both the synchroniser
    // output and the edge flop hold real samples. Without this, an input that is high
    // across reset would look like a fresh rising edge as the cleared chain refills.
    logic [SYNC_STAGES:0]   fill_q;
    logic                   s;

    assign s     = sync_q[SYNC_STAGES-1];
    assign level = s;

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            sync_q <= '0;
            s_d    <= 1'b0;
            fill_q <= '0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], PWM_i};
            s_d    <= s;
            fill_q <= {fill_q[SYNC_STAGES-1:0], 1'b1};
            rise   <= fill_q[SYNC_STAGES] &  s & ~s_d;
            fall   <= fill_q[SYNC_STAGES] & ~s &  s_d;
        end
    end

endmodule

// File: rtl/pwm_capture.sv
// Measures high time and rising-to-rising period of a PWM input; flags a stuck input.
// Latency: PWM_i rise -> Valid_o strobe SYNC_STAGES+2 clocks later.
// Backpressure: none; Valid_o is a 1-cycle strobe, results hold until the next strobe.
//
// Ports:
//   Clock      in   1      clock, posedge
//   Reset_n    in   1      synchronous active-low reset
//   PWM_i      in   1      asynchronous PWM input
//   High_o     out  WIDTH  high time of last complete period, cycles
//   Period_o   out  WIDTH  period of last complete period, cycles
//   Valid_o    out  1      High_o/Period_o updated this cycle
//   Timeout_o  out  1      no rising edge for TIMEOUT cycles; clears on next Valid_o
//   Level_o    out  1      synchronised PWM_i level
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int WIDTH       = PWM_WIDTH,
    parameter int SYNC_STAGES = PWM_SYNC_STAGES,
    parameter int TIMEOUT     = PWM_TIMEOUT
) (
    input  logic             Clock,
    input  logic             Reset_n,
    input  logic             PWM_i,
    output logic [WIDTH-1:0] High_o,
    output logic [WIDTH-1:0] Period_o,
    output logic             Valid_o,
    output logic             Timeout_o,
    output logic             Level_o
);

    localparam logic [WIDTH-1:0] TIMEOUT_CNT = WIDTH'(TIMEOUT);

    pwm_state_t       state;
    logic [WIDTH-1:0] period_cnt;
    logic [WIDTH-1:0] high_cnt;
    logic             rise;
    logic             fall;
    logic             timeout_hit;

    // Counters stick at all-ones rather than wrapping.
    function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
        return (&v) ? v : v + WIDTH'(1);
    endfunction

    pwm_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .PWM_i   (PWM_i),
        .level   (Level_o),
        .rise    (rise),
        .fall    (fall)
    );

    assign timeout_hit = (period_cnt == TIMEOUT_CNT);

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            state      <= S_WAIT;
            period_cnt <= '0;
            high_cnt   <= '0;
            High_o     <= '0;
            Period_o   <= '0;
            Valid_o    <= 1'b0;
            Timeout_o  <= 1'b0;
        end else begin
            Valid_o <= 1'b0;
            case (state)
                S_WAIT: begin
                    // The first rise only opens a measurement; nothing to report yet.
                    if (rise) begin
                        period_cnt <= WIDTH'(1);
                        high_cnt   <= WIDTH'(1);
                        state      <= S_HIGH;
                    end
                end
                S_HIGH: begin
                    if (timeout_hit) begin
                        Timeout_o <= 1'b1;
                        state     <= S_WAIT;
                    end else if (fall) begin
                        // high_cnt is frozen here: the falling cycle belongs to the low phase.
                        period_cnt <= sat_inc(period_cnt);
                        state      <= S_LOW;
                    end else begin
                        period_cnt <= sat_inc(period_cnt);
                        high_cnt   <= sat_inc(high_cnt);
                    end
                end
                S_LOW: begin
                    // A rise on the timeout cycle still completes the period.
                    if (rise) begin
                        Period_o   <= period_cnt;
                        High_o     <= high_cnt;
                        Valid_o    <= 1'b1;
                        Timeout_o  <= 1'b0;
                        period_cnt <= WIDTH'(1);
                        high_cnt   <= WIDTH'(1);
                        state      <= S_HIGH;
                    end else if (timeout_hit) begin
                        Timeout_o <= 1'b1;
                        state     <= S_WAIT;
                    end else begin
                        period_cnt <= sat_inc(period_cnt);
                    end
                end
                default: state <= S_WAIT;
            endcase
        end
    end

endmodule
